// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin shared comparator feeding a one-entry tagged response slot.
// Optional COMPARE_ARB_STATS_EN adds per-requester grant counters and a stall counter.
module compare_arbiter #(
  parameter int dataWidth = 32,
  parameter int selectWidth = 4,
  parameter int numRequesters = 4,
  parameter int idWidth = $clog2(numRequesters)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [numRequesters-1:0]           reqValid,
  output logic [numRequesters-1:0]           reqReady,
  input  logic [numRequesters*dataWidth-1:0] reqA,
  input  logic [numRequesters*dataWidth-1:0] reqB,
  input  logic [numRequesters*selectWidth-1:0] reqSelect,
  output logic                               respValid,
  input  logic                               respReady,
  output logic [idWidth-1:0]                 respId,
  output logic [dataWidth-1:0]               respData,
  output logic                               busy
`ifdef COMPARE_ARB_STATS_EN
  ,
  input  logic                               statsClear,
  output logic [numRequesters*16-1:0]        grantCount,
  output logic [15:0]                        stallCount
`endif
);
  logic [idWidth-1:0] lastGrant, winner, cand;
  logic found, slotFree, accept, result;
  logic [dataWidth-1:0] a_arr [numRequesters];
  logic [dataWidth-1:0] b_arr [numRequesters];
  logic [selectWidth-1:0] s_arr [numRequesters];
  int idx;
  for (genvar i = 0; i < numRequesters; i++) begin : g_unpack
    assign a_arr[i] = reqA[i*dataWidth +: dataWidth];
    assign b_arr[i] = reqB[i*dataWidth +: dataWidth];
    assign s_arr[i] = reqSelect[i*selectWidth +: selectWidth];
  end
  // one result bit per select code; unused codes stay 0
  function automatic logic compare(input logic [dataWidth-1:0] a, input logic [dataWidth-1:0] b,
                                   input logic [selectWidth-1:0] s);
    logic [(1<<selectWidth)-1:0] r;
    logic eq, lt, ltu;
    eq = a == b;
    lt = $signed(a) < $signed(b);
    ltu = a < b;
    r = '0;
    r[9:0] = {!ltu, !lt, !ltu && !eq, !lt && !eq, ltu || eq, lt || eq, ltu, lt, !eq, eq};
    return r[s];
  endfunction
  always_comb begin
    found = 1'b0;
    winner = '0;
    idx = 0;
    cand = '0;
    for (int k = 1; k <= numRequesters; k++) begin
      idx = (int'(lastGrant) + k) % numRequesters;
      cand = idWidth'(idx);
      if (!found && reqValid[cand]) begin
        found = 1'b1;
        winner = cand;
      end
    end
  end
  assign slotFree = !respValid || respReady;
  assign accept = found && slotFree;
  assign result = compare(a_arr[winner], b_arr[winner], s_arr[winner]);
  assign busy = respValid || (|reqValid);
  always_comb begin
    reqReady = '0;
    if (accept) reqReady[winner] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      respValid <= 1'b0;
      respId <= '0;
      respData <= '0;
      lastGrant <= idWidth'(numRequesters - 1);
    end else if (accept) begin
      respValid <= 1'b1;
      respId <= winner;
      respData <= {{(dataWidth-1){1'b0}}, result};
      lastGrant <= winner;
    end else if (respReady) begin
      respValid <= 1'b0;
    end
  end
`ifdef COMPARE_ARB_STATS_EN
  for (genvar i = 0; i < numRequesters; i++) begin : g_stats
    logic [15:0] gcnt;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) gcnt <= '0;
      else if (statsClear) gcnt <= '0;
      else if (reqValid[i] && reqReady[i] && gcnt != 16'hFFFF) gcnt <= gcnt + 16'd1;
    end
    assign grantCount[i*16 +: 16] = gcnt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stallCount <= '0;
    else if (statsClear) stallCount <= '0;
    else if (respValid && !respReady && (|reqValid) && stallCount != 16'hFFFF) stallCount <= stallCount + 16'd1;
  end
`endif
endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: vector table, directed corner sequences and randomized model check for compare_arbiter.
module tb_compare_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic [3:0] reqValid = '0;
  logic [3:0] reqReady;
  logic [127:0] reqA = '0;
  logic [127:0] reqB = '0;
  logic [15:0] reqSelect = '0;
  logic respValid;
  logic respReady = 0;
  logic [1:0] respId;
  logic [31:0] respData;
  logic busy;
`ifdef COMPARE_ARB_STATS_EN
  logic statsClear = 0;
  logic [63:0] grantCount;
  logic [15:0] stallCount;
`endif
  int checks = 0;
  int errors = 0;

  compare_arbiter dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
    .reqA(reqA), .reqB(reqB), .reqSelect(reqSelect),
    .respValid(respValid), .respReady(respReady), .respId(respId),
    .respData(respData), .busy(busy)
`ifdef COMPARE_ARB_STATS_EN
    , .statsClear(statsClear), .grantCount(grantCount), .stallCount(stallCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    logic [31:0] a;
    logic [31:0] b;
    int sel;
    bit exp;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input int sel);
    logic [31:0] s;
    s = sel;
    reqA[i*32 +: 32] = a;
    reqB[i*32 +: 32] = b;
    reqSelect[i*4 +: 4] = s[3:0];
  endtask

  task automatic do_reset();
    reqValid = '0;
    respReady = 0;
`ifdef COMPARE_ARB_STATS_EN
    statsClear = 0;
`endif
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    #1;
  endtask

  // comparison semantics computed with 64-bit arithmetic
  function automatic bit ref_cmp(input logic [31:0] a, input logic [31:0] b, input int sel);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (sel)
      0: return ua == ub;
      1: return ua != ub;
      2: return sa < sb;
      3: return ua < ub;
      4: return sa <= sb;
      5: return ua <= ub;
      6: return sa > sb;
      7: return ua > ub;
      8: return sa >= sb;
      9: return ua >= ub;
      default: return 0;
    endcase
  endfunction

  initial begin
    int mlast, mid, w, acc_w;
    bit mv, md, free;
    logic [31:0] av, bv;
    vecs[0]  = '{1, 32'd5, 32'd5, 0, 1'b1};
    vecs[1]  = '{0, 32'hFFFFFFFF, 32'd1, 2, 1'b1};
    vecs[2]  = '{0, 32'hFFFFFFFF, 32'd1, 3, 1'b0};
    vecs[3]  = '{3, 32'hFFFFFFFF, 32'd1, 12, 1'b0};
    vecs[4]  = '{2, 32'hFFFFFFFF, 32'd1, 1, 1'b1};
    vecs[5]  = '{2, 32'hFFFFFFFF, 32'd1, 4, 1'b1};
    vecs[6]  = '{1, 32'hFFFFFFFF, 32'd1, 5, 1'b0};
    vecs[7]  = '{3, 32'hFFFFFFFF, 32'd1, 6, 1'b0};
    vecs[8]  = '{0, 32'hFFFFFFFF, 32'd1, 7, 1'b1};
    vecs[9]  = '{1, 32'hFFFFFFFF, 32'd1, 8, 1'b0};
    vecs[10] = '{2, 32'hFFFFFFFF, 32'd1, 9, 1'b1};
    vecs[11] = '{3, 32'd7, 32'd7, 8, 1'b1};
    vecs[12] = '{0, 32'd7, 32'd7, 6, 1'b0};
    vecs[13] = '{1, 32'd5, 32'd5, 15, 1'b0};
    vecs[14] = '{2, 32'h80000000, 32'h7FFFFFFF, 0, 1'b0};
    vecs[15] = '{3, 32'h80000000, 32'h7FFFFFFF, 2, 1'b1};

    #3;
    chk("reset respValid", respValid, 0);
    chk("reset respId", respId, 0);
    chk("reset respData", respData, 0);
    chk("reset reqReady", reqReady, 0);
    chk("reset busy", busy, 0);
    do_reset();

    respReady = 1;
    foreach (vecs[n]) begin
      reqValid = '0;
      set_req(vecs[n].id, vecs[n].a, vecs[n].b, vecs[n].sel);
      reqValid[vecs[n].id] = 1'b1;
      #1 chk($sformatf("vec%0d reqReady", n), reqReady, 64'(1) << vecs[n].id);
      @(posedge clk);
      #1;
      reqValid = '0;
      chk($sformatf("vec%0d respValid", n), respValid, 1);
      chk($sformatf("vec%0d respId", n), respId, 64'(vecs[n].id));
      chk($sformatf("vec%0d respData", n), respData, 64'(vecs[n].exp));
    end
    @(posedge clk);
    #1;
    chk("drain respValid", respValid, 0);
    chk("drain respData held", respData, 64'(vecs[15].exp));
    chk("drain respId held", respId, 3);

    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, i, 2, 2);
    reqValid = 4'hF;
    respReady = 1;
    for (int n = 0; n < 6; n++) begin
      #1 chk($sformatf("rr%0d reqReady", n), reqReady, 64'(1) << (n % 4));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d respValid", n), respValid, 1);
      chk($sformatf("rr%0d respId", n), respId, 64'(n % 4));
    end
    reqValid = '0;

    do_reset();
    set_req(0, 1, 2, 2);
    reqValid = 4'b0001;
    respReady = 0;
    @(posedge clk);
    #1;
    reqValid = 4'b1100;
    set_req(2, 9, 9, 1);
    set_req(3, 9, 9, 0);
    for (int n = 0; n < 3; n++) begin
      #1;
      chk($sformatf("bp%0d reqReady", n), reqReady, 0);
      chk($sformatf("bp%0d respValid", n), respValid, 1);
      chk($sformatf("bp%0d respId", n), respId, 0);
      chk($sformatf("bp%0d respData", n), respData, 1);
      @(posedge clk);
      #1;
    end
    respReady = 1;
    #1 chk("bp release reqReady", reqReady, 4'b0100);
    @(posedge clk);
    #1;
    chk("bp next respValid", respValid, 1);
    chk("bp next respId", respId, 2);
    chk("bp next respData", respData, 0);

    reqValid = '0;
    respReady = 0;
    #2 reset = 1;
    #1;
    chk("async respValid", respValid, 0);
    chk("async respId", respId, 0);
    #1 reset = 0;
    set_req(0, 3, 4, 3);
    set_req(3, 3, 4, 0);
    reqValid = 4'b1001;
    respReady = 1;
    #1 chk("post-reset reqReady", reqReady, 4'b0001);
    @(posedge clk);
    #1;
    chk("post-reset respId", respId, 0);
    chk("post-reset respData", respData, 1);
    reqValid = '0;

`ifdef COMPARE_ARB_STATS_EN
    do_reset();
    set_req(2, 0, 0, 0);
    reqValid = 4'b0100;
    respReady = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("stats grant2", grantCount[32 +: 16], 5);
    chk("stats grant0", grantCount[0 +: 16], 0);
    chk("stats stall0", stallCount, 0);
    respReady = 0;
    reqValid = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    chk("stats stall3", stallCount, 3);
    statsClear = 1;
    reqValid = '0;
    @(posedge clk);
    #1;
    statsClear = 0;
    chk("stats cleared grants", grantCount, 0);
    chk("stats cleared stall", stallCount, 0);
`endif

    do_reset();
    mlast = 3;
    mv = 0;
    mid = 0;
    md = 0;
    acc_w = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!reqValid[i] || i == acc_w) begin
          reqValid[i] = ($urandom_range(0, 2) != 0);
          bv = $urandom;
          av = ($urandom_range(0, 3) == 0) ? bv : $urandom;
          set_req(i, av, bv, $urandom_range(0, 15));
        end
      end
      respReady = ($urandom_range(0, 3) != 0);
      #1;
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && reqValid[(mlast + k) % 4]) w = (mlast + k) % 4;
      free = !mv || respReady;
      chk("rand reqReady", reqReady, (w >= 0 && free) ? (64'(1) << w) : 64'(0));
      chk("rand busy", busy, 64'(mv || (reqValid != 0)));
      chk("rand respValid", respValid, 64'(mv));
      chk("rand respId", respId, 64'(mid));
      chk("rand respData", respData, 64'(md));
      @(posedge clk);
      acc_w = -1;
      if (w >= 0 && free) begin
        mv = 1;
        mid = w;
        md = ref_cmp(reqA[w*32 +: 32], reqB[w*32 +: 32], int'(reqSelect[w*4 +: 4]));
        mlast = w;
        acc_w = w;
      end else if (respReady) begin
        mv = 0;
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
